// File: rtl/seq_bin2bcd_signed.sv
// Sequential signed binary-to-BCD converter. It performs one shift-add-3 step per clock and
// produces a sign flag, DIGITS BCD digits of magnitude, and an overflow flag.
module seq_bin2bcd_signed #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  overflow
);

  // One guard digit above the visible ones holds |bin_in| exactly (2^IN_W <= 10^(DIGITS+1)).
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_scratch;
  logic [SW-1:0]       w_adj;
  logic [SW-1:0]       w_scratch_shift;
  logic [IN_W-1:0]     r_mag;
  logic [IN_W-1:0]     w_mag_in;
  logic [CW-1:0]       r_cnt;
  logic                r_sign;
  logic                w_accept;
  logic                w_last_shift;
  logic                w_ovf;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_neg;
  logic                r_ovf;

  // NOTE: every signal this block writes gets a default first; otherwise a missed branch infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    w_last_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == CW'(IN_W - 1)) begin
          w_last_shift = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS + 1; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
    w_scratch_shift = {w_adj[SW-2:0], r_mag[IN_W-1]};
    w_ovf           = |w_scratch_shift[SW-1:4*DIGITS];
    // The most-negative input negates to 2^(IN_W-1), which still fits unsigned in IN_W bits.
    w_mag_in        = bin_in[IN_W-1] ? ((~bin_in) + IN_W'(1)) : bin_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_scratch <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign    <= bin_in[IN_W-1];
        r_mag     <= w_mag_in;
        r_scratch <= '0;
        r_cnt     <= '0;
      end else if (r_state == S_SHIFT) begin
        r_scratch <= w_scratch_shift;
        r_mag     <= {r_mag[IN_W-2:0], 1'b0};
        r_cnt     <= r_cnt + CW'(1);
      end
      // Results are loaded as the final shift lands, so they are already valid while done is high.
      if (w_last_shift) begin
        r_ovf <= w_ovf;
        r_neg <= r_sign & (w_scratch_shift != '0);
        r_bcd <= w_ovf ? {DIGITS{4'h9}} : w_scratch_shift[4*DIGITS-1:0];
      end
    end
  end

  assign bcd_out  = r_bcd;
  assign neg      = r_neg;
  assign overflow = r_ovf;

endmodule
